// File: rtl/eq_cmp_arbiter.sv
// Shares one 32-bit equality comparator between two val/rdy requesters.
// Round-robin grant, one transaction in flight, registered operands and result.
module eq_cmp_arbiter #(
  parameter int unsigned p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               req0_val,
  output logic               req0_rdy,
  input  logic [p_nbits-1:0] req0_in0,
  input  logic [p_nbits-1:0] req0_in1,
  output logic               resp0_val,
  input  logic               resp0_rdy,
  output logic               resp0_eq,

  input  logic               req1_val,
  output logic               req1_rdy,
  input  logic [p_nbits-1:0] req1_in0,
  input  logic [p_nbits-1:0] req1_in1,
  output logic               resp1_val,
  input  logic               resp1_rdy,
  output logic               resp1_eq,

  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StCmp, StResp} state_e;

  state_e             state_q, state_d;
  logic               prio_q, prio_d;
  logic               gnt_q, gnt_d;
  logic               eq_q, eq_d;
  logic [p_nbits-1:0] op0_q, op0_d;
  logic [p_nbits-1:0] op1_q, op1_d;
  logic               cmp_eq;

  // Shared comparator, fed only from the operand registers.
  assign cmp_eq = (op0_q == op1_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      eq_q    <= 1'b0;
      op0_q   <= '0;
      op1_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      eq_q    <= eq_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    eq_d    = eq_q;
    op0_d   = op0_q;
    op1_d   = op1_q;
    unique case (state_q)
      StIdle: begin
        if (req0_rdy || req1_rdy) begin
          state_d = StCmp;
          gnt_d   = req1_rdy;
          op0_d   = req1_rdy ? req1_in0 : req0_in0;
          op1_d   = req1_rdy ? req1_in1 : req0_in1;
        end
      end
      StCmp: begin
        eq_d    = cmp_eq;
        state_d = StResp;
      end
      StResp: begin
        if (gnt_q ? resp1_rdy : resp0_rdy) begin
          state_d = StIdle;
          prio_d  = ~gnt_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Ties go to prio_q; a lone valid requester always wins.
  always_comb begin
    req0_rdy  = (state_q == StIdle) && !reset && req0_val && (!req1_val || !prio_q);
    req1_rdy  = (state_q == StIdle) && !reset && req1_val && (!req0_val ||  prio_q);
    resp0_val = (state_q == StResp) && !reset && !gnt_q;
    resp1_val = (state_q == StResp) && !reset &&  gnt_q;
    resp0_eq  = resp0_val && eq_q;
    resp1_eq  = resp1_val && eq_q;
    busy      = (state_q != StIdle) && !reset;
  end

endmodule

// File: tb/tb_eq_cmp_arbiter.sv
// Bench for eq_cmp_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level model.
module tb_eq_cmp_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_val;
  logic [1:0]  resp_rdy;
  logic [31:0] in0 [2];
  logic [31:0] in1 [2];
  logic        req0_rdy, req1_rdy, resp0_val, resp1_val, resp0_eq, resp1_eq, busy;
  logic [6:0]  obs;

  int n_cmp  = 0;
  int n_fail = 0;

  eq_cmp_arbiter #(.p_nbits(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_val  (req_val[0]),
    .req0_rdy  (req0_rdy),
    .req0_in0  (in0[0]),
    .req0_in1  (in1[0]),
    .resp0_val (resp0_val),
    .resp0_rdy (resp_rdy[0]),
    .resp0_eq  (resp0_eq),
    .req1_val  (req_val[1]),
    .req1_rdy  (req1_rdy),
    .req1_in0  (in0[1]),
    .req1_in1  (in1[1]),
    .resp1_val (resp1_val),
    .resp1_rdy (resp_rdy[1]),
    .resp1_eq  (resp1_eq),
    .busy      (busy)
  );

  assign obs = {busy, req1_rdy, req0_rdy, resp1_val, resp0_val, resp1_eq, resp0_eq};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          who;
    logic [31:0] a;
    logic [31:0] b;
    logic        eq;
  } vec_t;

  vec_t vecs [8];

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // obs bits: busy, rdy1, rdy0, rv1, rv0, eq1, eq0
  task automatic chk_o(input string nm, input logic [6:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (busy,rdy1,rdy0,rv1,rv0,eq1,eq0) t=%0t",
               nm, obs, exp, $time);
    end
  endtask

  task automatic chk_v(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Starts and ends at a drive point with the DUT idle.
  task automatic run_txn(input string nm, input int who, input logic [31:0] a,
                         input logic [31:0] b, input logic eq);
    logic [1:0] oh;
    oh = (who == 0) ? 2'b01 : 2'b10;
    req_val  = oh;
    in0[who] = a;
    in1[who] = b;
    resp_rdy = 2'b11;
    smp(); chk_o({nm, "_acc"}, {1'b0, oh, 2'b00, 2'b00});
    drv(); req_val = 2'b00;
    smp(); chk_o({nm, "_cmp"}, {1'b1, 2'b00, 2'b00, 2'b00});
    drv();
    smp(); chk_o({nm, "_resp"}, {1'b1, 2'b00, oh, eq ? oh : 2'b00});
    drv();
    smp(); chk_o({nm, "_idle"}, 7'b0);
    drv();
  endtask

  // Transaction-level reference model state
  logic        m_out, m_owner, m_prio, m_eq;
  int          m_age;
  logic [1:0]  acc;
  logic        rsp_pend, cap_eq;
  logic [1:0]  e_rdy, e_rv, e_eq;
  int          n_done, cyc;

  initial begin
    vecs[0] = '{0, 32'h12345678, 32'h12345678, 1'b1};
    vecs[1] = '{1, 32'hAAAAAAAA, 32'h55555555, 1'b0};
    vecs[2] = '{0, 32'h00000000, 32'h00000000, 1'b1};
    vecs[3] = '{1, 32'h80000000, 32'h00000000, 1'b0};
    vecs[4] = '{0, 32'h00000001, 32'h00000000, 1'b0};
    vecs[5] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
    vecs[6] = '{0, 32'hDEADBEEF, 32'hDEADBEEE, 1'b0};
    vecs[7] = '{1, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0};

    // Reset with both requesters already valid, then contention.
    reset    = 1'b1;
    req_val  = 2'b11;
    resp_rdy = 2'b11;
    in0[0] = 32'hFFFFFFFF; in1[0] = 32'hFFFFFFFF;
    in0[1] = 32'h00000000; in1[1] = 32'h00000001;
    smp(); chk_o("reset_c1", 7'b0);
    drv();
    smp(); chk_o("reset_c2", 7'b0);
    drv(); reset = 1'b0;
    smp(); chk_o("cont_acc0", 7'b0_01_00_00);
    drv();
    smp(); chk_o("cont_cmp0", 7'b1_00_00_00);
    drv();
    smp(); chk_o("cont_resp0", 7'b1_00_01_01);
    drv();
    smp(); chk_o("cont_acc1", 7'b0_10_00_00);
    drv();
    smp(); chk_o("cont_cmp1", 7'b1_00_00_00);
    drv();
    smp(); chk_o("cont_resp1", 7'b1_00_10_00);
    drv();
    smp(); chk_o("cont_acc0b", 7'b0_01_00_00);
    drv(); req_val = 2'b00;
    smp(); chk_o("cont_cmp0b", 7'b1_00_00_00);
    drv();
    smp(); chk_o("cont_resp0b", 7'b1_00_01_01);
    drv();
    smp(); chk_o("cont_idle", 7'b0);
    drv();

    for (int i = 0; i < 8; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].eq);

    // Backpressure on requester 0 while requester 1 waits.
    req_val  = 2'b01;
    resp_rdy = 2'b10;
    in0[0] = 32'hCAFEF00D; in1[0] = 32'hCAFEF00D;
    smp(); chk_o("bp_acc", 7'b0_01_00_00);
    drv(); req_val = 2'b10; in0[1] = 32'd5; in1[1] = 32'd6;
    smp(); chk_o("bp_cmp", 7'b1_00_00_00);
    for (int i = 0; i < 5; i++) begin
      drv();
      smp(); chk_o($sformatf("bp_hold%0d", i), 7'b1_00_01_01);
    end
    drv(); resp_rdy = 2'b11;
    smp(); chk_o("bp_release", 7'b1_00_01_01);
    drv();
    smp(); chk_o("bp_idle_acc1", 7'b0_10_00_00);
    drv(); req_val = 2'b00;
    smp(); chk_o("bp_cmp1", 7'b1_00_00_00);
    drv();
    smp(); chk_o("bp_resp1", 7'b1_00_10_00);
    drv();
    smp(); chk_o("bp_idle", 7'b0);
    drv();

    // Make prio point at requester 1, then abort a requester-0 transaction in CMP.
    run_txn("pre_abort", 0, 32'h1, 32'h1, 1'b1);
    req_val = 2'b01; in0[0] = 32'h77; in1[0] = 32'h77;
    smp(); chk_o("abort_acc", 7'b0_01_00_00);
    drv(); req_val = 2'b00;
    smp(); chk_o("abort_cmp", 7'b1_00_00_00);
    drv(); reset = 1'b1;
    smp(); chk_o("abort_in_reset", 7'b0);
    drv(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp(); chk_o($sformatf("abort_quiet%0d", i), 7'b0);
      drv();
    end
    req_val = 2'b11;
    in0[0] = 32'h3; in1[0] = 32'h3; in0[1] = 32'h4; in1[1] = 32'h4;
    smp(); chk_o("abort_prio_reset", 7'b0_01_00_00);

    // Randomized traffic against the transaction-level model.
    drv(); reset = 1'b1; req_val = 2'b00;
    drv(); reset = 1'b0;
    m_out = 1'b0; m_owner = 1'b0; m_prio = 1'b0; m_eq = 1'b0; m_age = 0;
    acc = 2'b00; rsp_pend = 1'b0; cap_eq = 1'b0;
    n_done = 0; cyc = 0;
    while (n_done < 100 && cyc < 5000) begin
      for (int k = 0; k < 2; k++) begin
        if (!(req_val[k] && !acc[k])) begin
          int unsigned mode;
          req_val[k] = ($urandom_range(1) == 1);
          in0[k] = $urandom;
          mode = $urandom_range(2);
          if (mode == 0)      in1[k] = in0[k];
          else if (mode == 1) in1[k] = in0[k] ^ (32'h1 << $urandom_range(31));
          else                in1[k] = $urandom;
        end
      end
      resp_rdy = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
      smp();
      e_rdy[0] = !m_out && req_val[0] && (!req_val[1] || !m_prio);
      e_rdy[1] = !m_out && req_val[1] && (!req_val[0] ||  m_prio);
      e_rv     = (m_out && m_age >= 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      e_eq     = m_eq ? e_rv : 2'b00;
      chk_o($sformatf("rand_c%0d", cyc), {m_out, e_rdy, e_rv, e_eq});
      acc      = req_val & e_rdy;
      cap_eq   = acc[1] ? (in0[1] == in1[1]) : (in0[0] == in1[0]);
      rsp_pend = |(e_rv & resp_rdy);
      @(posedge clk);
      if (|acc) begin
        m_out = 1'b1; m_owner = acc[1]; m_eq = cap_eq; m_age = 0;
      end else if (rsp_pend) begin
        m_out = 1'b0; m_prio = ~m_owner; n_done++;
      end else if (m_out) begin
        m_age++;
      end
      #1;
      cyc++;
    end
    chk_v("rand_done", n_done, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
